// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port round-robin arbiter and read sequencer for a 16x16
// synchronous-address ROM. Grants one requester at a time and drives the
// ROM address/output-enable in ADDR -> READ order. It captures the word in
// READ and returns it with a one-cycle acknowledge in DONE.
//
// state | meaning
// IDLE  | waiting for a request; a grant happens on the edge leaving IDLE
// ADDR  | rom_a stable with rom_oe low; the ROM latches the address
// READ  | rom_oe high for this single cycle; rom_q captured at its end
// DONE  | ack of the owner high, dout valid; always returns to IDLE
//
// Ports:
//   ck, rst        clock, asynchronous active-high reset
//   req0, a0       requester 0 level request and word address
//   req1, a1       requester 1 level request and word address
//   ack0, ack1     one-cycle pulse: dout holds that requester's word
//   dout           registered read data, held until the next READ
//   busy           high in every state except IDLE
//   rom_a, rom_oe  ROM address and output enable (sole driver)
//   rom_q          ROM data, only meaningful while rom_oe is high

module rom_arbiter (
   input  logic        ck,
   input  logic        rst,
   input  logic        req0,
   input  logic [3:0]  a0,
   input  logic        req1,
   input  logic [3:0]  a1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] dout,
   output logic        busy,
   output logic [3:0]  rom_a,
   output logic        rom_oe,
   input  logic [15:0] rom_q
);

   typedef enum logic [1:0] {IDLE, ADDR, READ, DONE} state_t;

   state_t state, state_nxt;
   logic   owner;
   logic   last;
   logic   grant;
   logic   win;

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      win       = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant     = 1'b1;
               // on a tie the requester that did not win last time goes first
               win       = (req0 && req1) ? ~last : req1;
               state_nxt = ADDR;
            end
         end
         ADDR:    state_nxt = READ;
         READ:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         rom_a  <= 4'h0;
         rom_oe <= 1'b0;
         owner  <= 1'b0;
         last   <= 1'b1;
         dout   <= 16'h0000;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
      end else begin
         // registered so the enable is high for exactly the READ cycle
         rom_oe <= (state_nxt == READ);
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         if (grant) begin
            rom_a <= win ? a1 : a0;
            owner <= win;
            last  <= win;
         end
         if (state == READ) begin
            dout <= rom_q;
            ack0 <= ~owner;
            ack1 <= owner;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
